// File: rtl/buffer_write_arbiter.sv
// buffer_write_arbiter: round-robin fan-in of REQUESTERS writers into a single-entry
// buffer with a registered read side. A writer is granted only when the slot is free
// or is being drained in the same cycle, so a full buffer never drops data.
module buffer_write_arbiter #(
  parameter int WIDTH        = 8,
  parameter int REQUESTERS   = 4,
  parameter int SOURCE_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [REQUESTERS-1:0]         write_request,
  input  logic [REQUESTERS*WIDTH-1:0]   write_data,
  output logic [REQUESTERS-1:0]         write_grant,
  output logic                          full,
  output logic                          empty,
  input  logic                          read_enable,
  output logic [WIDTH-1:0]              read_data,
  output logic [SOURCE_WIDTH-1:0]       read_source
);

  logic [WIDTH-1:0]        buffer;
  logic [SOURCE_WIDTH-1:0] buffer_source;
  logic                    buffer_valid;
  logic [SOURCE_WIDTH-1:0] pointer;

  logic                    can_write;
  logic                    found;
  logic                    grant;
  logic [SOURCE_WIDTH-1:0] winner;
  logic [WIDTH-1:0]        winner_data;
  logic [SOURCE_WIDTH-1:0] next_pointer;

  // Slot is writable when empty, or when the reader drains it this same edge.
  assign can_write = ~buffer_valid | read_enable;

  // Scan from the pointer, wrapping, and pick the first active request.
  always_comb begin
    int idx;
    found       = 1'b0;
    winner      = '0;
    winner_data = '0;
    idx         = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = int'(pointer) + k;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!found && write_request[idx]) begin
        found       = 1'b1;
        winner      = SOURCE_WIDTH'(idx);
        winner_data = write_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign grant = found & can_write;

  // Decode the winner into a one-hot grant, or all zero when not accepting.
  always_comb begin
    write_grant = '0;
    for (int i = 0; i < REQUESTERS; i++)
      write_grant[i] = grant && (winner == SOURCE_WIDTH'(i));
  end

  // Pointer moves one past the winner so the winner has lowest priority next time.
  always_comb begin
    if (winner == SOURCE_WIDTH'(REQUESTERS - 1)) next_pointer = '0;
    else                                         next_pointer = winner + 1'b1;
  end

  // Buffer update: a grant overwrites (covering the read-and-write case without a
  // bubble); a read alone just clears valid and leaves the stale data in place.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buffer        <= '0;
      buffer_source <= '0;
      buffer_valid  <= 1'b0;
      pointer       <= '0;
    end else if (grant) begin
      buffer        <= winner_data;
      buffer_source <= winner;
      buffer_valid  <= 1'b1;
      pointer       <= next_pointer;
    end else if (read_enable && buffer_valid) begin
      buffer_valid  <= 1'b0;
    end
  end

  assign full        = buffer_valid;
  assign empty       = ~buffer_valid;
  assign read_data   = buffer;
  assign read_source = buffer_source;

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter (4 requesters, 8-bit data).
module tb_buffer_write_arbiter;

  logic        clock;
  logic        resetn;
  logic [3:0]  write_request;
  logic [31:0] write_data;
  logic [3:0]  write_grant;
  logic        full;
  logic        empty;
  logic        read_enable;
  logic [7:0]  read_data;
  logic [1:0]  read_source;

  int checks = 0;
  int passed = 0;
  logic [7:0] dv [4] = '{8'h10, 8'hA5, 8'h22, 8'h33};

  buffer_write_arbiter #(.WIDTH(8), .REQUESTERS(4)) dut (
    .clock(clock), .resetn(resetn),
    .write_request(write_request), .write_data(write_data),
    .write_grant(write_grant), .full(full), .empty(empty),
    .read_enable(read_enable), .read_data(read_data), .read_source(read_source)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b1; write_request = 4'h0; read_enable = 1'b0;
    write_data = {8'h33, 8'h22, 8'hA5, 8'h10};
    #2 resetn = 1'b0;
    tick; tick;
    checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
    checks++; if (read_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", read_data); else passed++;
    checks++; if (read_source !== 2'd0) $display("FAIL reset_source: got %0d expected 0", read_source); else passed++;
    checks++; if (write_grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", write_grant); else passed++;
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_single;
    write_request = 4'b0010;
    #1;
    checks++; if (write_grant !== 4'b0010) $display("FAIL single_grant: got %b expected 0010", write_grant); else passed++;
    tick;
    write_request = 4'b0000;
    checks++; if (full !== 1'b1) $display("FAIL single_full: got %b expected 1", full); else passed++;
    checks++; if (read_data !== 8'hA5) $display("FAIL single_data: got %h expected a5", read_data); else passed++;
    checks++; if (read_source !== 2'd1) $display("FAIL single_source: got %0d expected 1", read_source); else passed++;
    read_enable = 1'b1;
    tick;
    read_enable = 1'b0;
    checks++; if (empty !== 1'b1) $display("FAIL single_drain: got empty=%b expected 1", empty); else passed++;
  endtask

  task automatic test_back_to_back;
    // Restart from pointer 0 so the rotation begins at requester 0.
    resetn = 1'b0; #1 resetn = 1'b1;
    write_request = 4'hF; read_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (write_grant !== (4'b0001 << (k % 4)))
        $display("FAIL rr_grant%0d: got %b expected %b", k, write_grant, 4'b0001 << (k % 4));
      else passed++;
      tick;
      checks++;
      if (read_source !== 2'(k % 4) || read_data !== dv[k % 4] || full !== 1'b1)
        $display("FAIL rr_read%0d: got src=%0d data=%h full=%b expected src=%0d data=%h full=1",
                 k, read_source, read_data, full, k % 4, dv[k % 4]);
      else passed++;
    end
    write_request = 4'h0; read_enable = 1'b0;
  endtask

  task automatic test_backpressure;
    // Buffer holds requester 0's entry; pointer is 1.
    write_request = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (write_grant !== 4'b0000) $display("FAIL bp_grant%0d: got %b expected 0000", k, write_grant); else passed++;
      tick;
      checks++;
      if (read_data !== 8'h10 || full !== 1'b1)
        $display("FAIL bp_hold%0d: got data=%h full=%b expected data=10 full=1", k, read_data, full);
      else passed++;
    end
    read_enable = 1'b1;
    #1;
    checks++; if (write_grant !== 4'b0100) $display("FAIL bp_release_grant: got %b expected 0100", write_grant); else passed++;
    tick;
    write_request = 4'h0; read_enable = 1'b0;
    checks++;
    if (full !== 1'b1 || read_data !== 8'h22 || read_source !== 2'd2)
      $display("FAIL bp_release_read: got full=%b data=%h src=%0d expected full=1 data=22 src=2", full, read_data, read_source);
    else passed++;
  endtask

  task automatic test_pointer_wrap;
    // Pointer is 3: scan 3,0 -> requester 0.
    write_request = 4'b0101; read_enable = 1'b1;
    #1;
    checks++; if (write_grant !== 4'b0001) $display("FAIL wrap_grant: got %b expected 0001", write_grant); else passed++;
    tick;
    checks++; if (read_source !== 2'd0) $display("FAIL wrap_source: got %0d expected 0", read_source); else passed++;
    // Pointer now 1: scan 1,2 -> requester 2.
    #1;
    checks++; if (write_grant !== 4'b0100) $display("FAIL skip_grant: got %b expected 0100", write_grant); else passed++;
    tick;
    checks++; if (read_source !== 2'd2) $display("FAIL skip_source: got %0d expected 2", read_source); else passed++;
    write_request = 4'h0;
    tick;
    read_enable = 1'b0;
    checks++; if (empty !== 1'b1) $display("FAIL wrap_drain: got empty=%b expected 1", empty); else passed++;
  endtask

  task automatic test_read_empty;
    read_enable = 1'b1;
    tick;
    read_enable = 1'b0;
    checks++;
    if (empty !== 1'b1 || read_data !== 8'h22 || read_source !== 2'd2)
      $display("FAIL read_empty: got empty=%b data=%h src=%0d expected empty=1 data=22 src=2", empty, read_data, read_source);
    else passed++;
  endtask

  task automatic test_mid_reset;
    // Pointer 3: scan 3,0,1 -> requester 1.
    write_request = 4'b0010;
    #1;
    checks++; if (write_grant !== 4'b0010) $display("FAIL mr_fill_grant: got %b expected 0010", write_grant); else passed++;
    tick;
    write_request = 4'h0;
    checks++; if (full !== 1'b1) $display("FAIL mr_fill_full: got %b expected 1", full); else passed++;
    resetn = 1'b0;
    #1;
    checks++;
    if (full !== 1'b0 || empty !== 1'b1 || read_data !== 8'h00 || read_source !== 2'd0)
      $display("FAIL mr_reset: got full=%b empty=%b data=%h src=%0d expected 0 1 00 0", full, empty, read_data, read_source);
    else passed++;
    resetn = 1'b1;
    // Pointer back at 0: requester 0 beats requester 3 (pointer 2 would pick 3).
    write_request = 4'b1001;
    #1;
    checks++; if (write_grant !== 4'b0001) $display("FAIL mr_grant: got %b expected 0001", write_grant); else passed++;
    tick;
    write_request = 4'h0;
    checks++;
    if (read_source !== 2'd0 || read_data !== 8'h10)
      $display("FAIL mr_read: got src=%0d data=%h expected src=0 data=10", read_source, read_data);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_pointer_wrap;
    test_read_empty;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
